// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: register address and writeback entry layout.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; 'entries' is presented in age order
// (index 0 = oldest) so consumers can scan pending results without pointer math.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count,
    output wb_entry_t              head,
    output wb_entry_t [DEPTH-1:0]  entries
);

    wb_entry_t [DEPTH-1:0] mem_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; flush rewinds pointers but leaves stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r    <= '0;
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Rotate storage into age order starting at the read pointer.
    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem_r[rd_ptr_r + AW'(i)];
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback stage: buffers ALU results and drains them to the register file.
// Build option WB_BYPASS_EN adds operand forwarding from pending entries.
module alu_wb_stage
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic              rf_wready,
    output logic [CW-1:0]     pending,
    output logic [31:0]       retire_cnt
`ifdef WB_BYPASS_EN
   ,input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic [XLEN-1:0]   fwd2_data
`endif
);

    logic                  full_s;
    logic                  empty_s;
    logic [CW-1:0]         count_s;
    wb_entry_t             head_s;
    wb_entry_t             push_entry_s;
    logic                  push_s;
    logic                  pop_s;
    logic [31:0]           retire_cnt_r;

    // Full blocks acceptance for the whole cycle even if the head retires now.
    assign in_ready     = !full_s && !flush;
    assign push_s       = in_valid && in_ready && (in_rd != {REG_AW{1'b0}});
    assign rf_we        = !empty_s && !flush;
    assign pop_s        = rf_we && rf_wready;
    assign rf_waddr     = head_s.rd;
    assign rf_wdata     = head_s.data;
    assign pending      = count_s;
    assign retire_cnt   = retire_cnt_r;
    assign push_entry_s = '{rd: in_rd, data: in_data};

`ifdef WB_BYPASS_EN
    wb_entry_t [DEPTH-1:0] entries_s;
    logic [DEPTH-1:0]      m1_s;
    logic [DEPTH-1:0]      m2_s;

    // Per-entry match against live (counted) slots; x0 never forwards.
    always_comb begin
        m1_s = {DEPTH{1'b0}};
        m2_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            m1_s[i] = (CW'(i) < count_s) && (entries_s[i].rd == rs1_addr)
                      && (rs1_addr != {REG_AW{1'b0}});
            m2_s[i] = (CW'(i) < count_s) && (entries_s[i].rd == rs2_addr)
                      && (rs2_addr != {REG_AW{1'b0}});
        end
    end

    // Scan oldest to youngest so the youngest match overrides older ones.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = {XLEN{1'b0}};
        fwd2_data = {XLEN{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd1_hit  = fwd1_hit | m1_s[i];
            fwd2_hit  = fwd2_hit | m2_s[i];
            fwd1_data = m1_s[i] ? entries_s[i].data : fwd1_data;
            fwd2_data = m2_s[i] ? entries_s[i].data : fwd2_data;
        end
    end
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (flush),
        .full       (full_s),
        .empty      (empty_s),
        .count      (count_s),
        .head       (head_s),
`ifdef WB_BYPASS_EN
        .entries    (entries_s)
`else
        .entries    ()
`endif
    );

    // Completed-write counter; wraps naturally and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= 32'd0;
        end else if (pop_s) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage (default DEPTH=2).
module tb_alu_wb_stage;
    import riscv_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_data;
    logic              flush;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              rf_wready;
    logic [1:0]        pending;
    logic [31:0]       retire_cnt;
`ifdef WB_BYPASS_EN
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [XLEN-1:0]   fwd1_data;
    logic [XLEN-1:0]   fwd2_data;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_retire = 32'd0;

    alu_wb_stage #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .flush      (flush),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_wready  (rf_wready),
        .pending    (pending),
        .retire_cnt (retire_cnt)
`ifdef WB_BYPASS_EN
       ,.rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
        flush = 1'b0; rf_wready = 1'b0;
`ifdef WB_BYPASS_EN
        rs1_addr = '0; rs2_addr = '0;
`endif
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b want=0", rf_we); end
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL reset_retire got=%0d want=0", retire_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single();
        cyc();
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF; rf_wready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", in_ready); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_n got=%b want=0", rf_we); end
        cyc();
        in_valid = 1'b0;
        #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b want=1", rf_we); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL single_addr got=%0d want=5", rf_waddr); end
        total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h want=deadbeef", rf_wdata); end
        total++; if (pending !== 2'd1) begin bad++; $display("FAIL single_pend1 got=%0d want=1", pending); end
        cyc();
        exp_retire = exp_retire + 32'd1;
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL single_pend0 got=%0d want=0", pending); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_done got=%b want=0", rf_we); end
        total++; if (retire_cnt !== exp_retire) begin bad++; $display("FAIL single_retire got=%0d want=%0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_back_to_back();
        rf_wready = 1'b0;
        in_valid = 1'b1; in_rd = 5'd1; in_data = 32'hA1;
        cyc();
        in_rd = 5'd2; in_data = 32'hA2;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b want=1", in_ready); end
        cyc();
        in_rd = 5'd3; in_data = 32'hA3;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", in_ready); end
        total++; if (pending !== 2'd2) begin bad++; $display("FAIL b2b_pend2 got=%0d want=2", pending); end
        cyc();
        total++; if (rf_waddr !== 5'd1 || rf_wdata !== 32'hA1) begin bad++; $display("FAIL b2b_hold got=%0d/%h want=1/a1", rf_waddr, rf_wdata); end
        total++; if (pending !== 2'd2) begin bad++; $display("FAIL b2b_stall got=%0d want=2", pending); end
        rf_wready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_no_reopen got=%b want=0", in_ready); end
        cyc();
        total++; if (in_ready !== 1'b1 || rf_waddr !== 5'd2) begin bad++; $display("FAIL b2b_second got=%b/%0d want=1/2", in_ready, rf_waddr); end
        cyc();
        in_valid = 1'b0;
        #1;
        total++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'hA3 || pending !== 2'd1) begin bad++; $display("FAIL b2b_third got=%0d/%h/%0d want=3/a3/1", rf_waddr, rf_wdata, pending); end
        cyc();
        exp_retire = exp_retire + 32'd3;
        total++; if (pending !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%0d/%b want=0/1", pending, in_ready); end
        total++; if (retire_cnt !== exp_retire) begin bad++; $display("FAIL b2b_retire got=%0d want=%0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_x0_drop();
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'h1234; rf_wready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b want=1", in_ready); end
        cyc();
        in_valid = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL x0_noenq got=%b/%0d want=0/0", rf_we, pending); end
        cyc();
        total++; if (retire_cnt !== exp_retire) begin bad++; $display("FAIL x0_retire got=%0d want=%0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_flush();
        rf_wready = 1'b0;
        in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h90;
        cyc();
        in_rd = 5'd10; in_data = 32'hA0;
        cyc();
        flush = 1'b1; in_rd = 5'd11; in_data = 32'hB0;
        #1;
        total++; if (in_ready !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL flush_comb got=%b/%b want=0/0", in_ready, rf_we); end
        cyc();
        flush = 1'b0; in_valid = 1'b0; rf_wready = 1'b1;
        #1;
        total++; if (pending !== 2'd0 || rf_we !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0d/%b want=0/0", pending, rf_we); end
        cyc();
        total++; if (retire_cnt !== exp_retire) begin bad++; $display("FAIL flush_retire got=%0d want=%0d", retire_cnt, exp_retire); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        rf_wready = 1'b0;
        rs1_addr = 5'd7; rs2_addr = 5'd0;
        in_valid = 1'b1; in_rd = 5'd7; in_data = 32'h11;
        #1;
        total++; if (fwd1_hit !== 1'b0) begin bad++; $display("FAIL byp_incoming got=%b want=0", fwd1_hit); end
        cyc();
        in_data = 32'h22;
        #1;
        total++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h11) begin bad++; $display("FAIL byp_one got=%b/%h want=1/11", fwd1_hit, fwd1_data); end
        cyc();
        in_valid = 1'b0;
        #1;
        total++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin bad++; $display("FAIL byp_young got=%b/%h want=1/22", fwd1_hit, fwd1_data); end
        total++; if (fwd2_hit !== 1'b0) begin bad++; $display("FAIL byp_x0 got=%b want=0", fwd2_hit); end
        flush = 1'b1;
        cyc();
        flush = 1'b0; rs1_addr = 5'd0;
    endtask
`endif

    task automatic test_wrap_reset();
        force dut.retire_cnt_r = 32'hFFFFFFFE;
        #1;
        release dut.retire_cnt_r;
        rf_wready = 1'b0;
        in_valid = 1'b1; in_rd = 5'd3; in_data = 32'h33;
        cyc();
        in_rd = 5'd4; in_data = 32'h44;
        cyc();
        in_valid = 1'b0; rf_wready = 1'b1;
        cyc();
        total++; if (retire_cnt !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffffffff", retire_cnt); end
        cyc();
        total++; if (retire_cnt !== 32'd0 || pending !== 2'd0) begin bad++; $display("FAIL wrap_zero got=%h/%0d want=0/0", retire_cnt, pending); end
        rf_wready = 1'b0;
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h55;
        cyc();
        in_rd = 5'd6; in_data = 32'h66;
        cyc();
        in_valid = 1'b0; rf_wready = 1'b1;
        #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin bad++; $display("FAIL rst_pre got=%b/%0d want=1/5", rf_we, rf_waddr); end
        cyc();
        rst_n = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL rst_async got=%b/%0d want=0/0", rf_we, pending); end
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL rst_retire got=%0d want=0", retire_cnt); end
        cyc();
        rst_n = 1'b1;
        cyc();
        total++; if (rf_we !== 1'b0 || pending !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_after got=%b/%0d/%b want=0/0/1", rf_we, pending, in_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_x0_drop();
        test_flush();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
